id_ex_stage: RTL and testbench
==============================

ID_EX_STAGE -- requirements
Module: id_ex_stage

Interface
REQ-001 SHALL have port clk, input, 1, sole clock; all state updates on rising edge.
REQ-002 SHALL have port reset, input, 1; reset is asynchronous and active-high.
REQ-003 SHALL have port in_valid, input, 1: decode slot holds an instruction.
REQ-004 SHALL have port in_ready, output, 1: stage accepts the decode slot this cycle (0 = stall).
REQ-005 SHALL have ports in_rs1_data/in_rs2_data/in_imm/in_pc, input, 32 each: regfile reads, sign-extended immediate, and PC.
REQ-006 SHALL have ports in_rs1/in_rs2/in_rd, input, 5 each: register addresses.
REQ-007 SHALL have port in_op, input, 2: 00 R-type, 01 I-type ALU, 10 load/store, 11 branch.
REQ-008 SHALL have ports in_funct3 (3), in_funct7b5 (1), in_mem_read, in_mem_write, in_reg_write (1 each), all inputs.
REQ-009 SHALL have port flush, input, 1: squash the instruction entering EX.
REQ-010 SHALL have ports ex_result (input, 32), the current ALU result; and mem_rd (5), mem_reg_write (1), mem_result (32), all inputs, from the MEM stage.
REQ-011 SHALL have output ports out_valid (1), A (32), B (32), ALUcontrol (4), out_store_data (32), out_rd (5), out_mem_read, out_mem_write, out_reg_write, out_branch (1 each), and out_pc (32), all registered.

Function
REQ-012 SHALL drive ALUcontrol with this encoding: AND 0000, OR 0001, ADD 0010, XOR 0011, SLL 0100, SRL 0101, SUB 0110, SRA 0111, unsupported 1111.
REQ-013 SHALL decode R-type funct3 as: 000 ADD, or SUB when funct7b5=1; 100 XOR; 110 OR; 111 AND; 001 SLL; 101 SRL, or SRA when funct7b5=1; 010/011 give 1111.
REQ-014 SHALL decode I-type the same way, except funct3 000 is always ADD.
REQ-015 SHALL decode load/store as ADD and branch as SUB, with out_branch=1 for branches.
REQ-016 SHALL select B as forwarded rs2 for R-type and branch, and as in_imm for I-type and load/store.
REQ-017 SHALL, for shifts (funct3 001/101), zero-extend B from bits [4:0] of the selected operand.
REQ-018 SHALL drive out_store_data as the forwarded rs2 value, regardless of in_op.
REQ-019 SHALL apply forwarding priority EX stage (own output registers out_rd/out_reg_write/out_valid, value ex_result), then MEM stage, then regfile data.
REQ-020 SHALL never forward for register 0.
REQ-021 SHALL detect a load-use hazard when out_valid & out_mem_read & out_rd!=0 and out_rd matches in_rs1, or matches in_rs2 on R-type/branch/store.
REQ-022 SHALL, on a hazard, drive in_ready=0 and load a bubble (out_valid=0, all control outputs 0) into the output registers.
REQ-023 SHALL, when in_valid=0, load a bubble and drive in_ready=1.
REQ-024 SHALL give flush priority over a stall: a bubble loads next edge and in_ready=1.
REQ-025 SHALL otherwise load all outputs from the decode slot with 1-cycle latency, out_valid=1.

Reset
REQ-026 SHALL, while reset=1, immediately force out_valid, all control outputs, A, B, out_store_data, out_rd and out_pc to 0 and ALUcontrol to 1111.
REQ-027 SHALL accept the first instruction on the first rising edge after reset deasserts; a reset asserted mid-stall drops the stalled instruction from EX.

Configuration
REQ-028 SHALL use macro FORWARDING_EN: when defined, REQ-019..REQ-021 apply.
REQ-029 SHALL, when FORWARDING_EN is undefined, use regfile data only and stall on any match of a nonzero rs1/rs2 with a valid writing instruction in EX or MEM, rs2 being matched only on R-type/branch/store as in REQ-021.

Verification
REQ-030 SHALL cover: R-type funct3=101, funct7b5=1, rs1=0x80000000, rs2=0x24 -> next cycle ALUcontrol=0111, A=0x80000000, B=0x4.
REQ-031 SHALL cover: `add x5` in EX with ex_result=0x1234, then R-type rs1=x5 -> A=0x1234 (with FORWARDING_EN); without the macro -> in_ready=0 for 2 cycles.
REQ-032 SHALL cover: load to x7 in EX, next instruction uses rs2=x7 (R-type) -> in_ready=0 for 1 cycle, a bubble out, then forwarded mem_result in B.
REQ-033 SHALL cover: flush=1 during a load-use stall -> out_valid=0 next cycle and in_ready=1.
REQ-034 SHALL cover: instruction with rs1=x0 while EX writes x0 with ex_result=0xFFFF -> A=in_rs1_data (0), no stall.
REQ-035 SHALL cover: reset asserted mid-stream between edges -> outputs 0 and ALUcontrol=1111 without waiting for clk.

Source files
------------

// File: rtl/id_ex_stage.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | id_ex_stage: ID/EX pipeline register with ALU decode, operand select,  |
// | EX/MEM forwarding and load-use stall. Optional macro: FORWARDING_EN.   |
// | Revision: 1.0                                                          |
// +------------------------------------------------------------------------+
module id_ex_stage (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_rs1_data,
  input  logic [31:0] in_rs2_data,
  input  logic [31:0] in_imm,
  input  logic [31:0] in_pc,
  input  logic [4:0]  in_rs1,
  input  logic [4:0]  in_rs2,
  input  logic [4:0]  in_rd,
  input  logic [1:0]  in_op,
  input  logic [2:0]  in_funct3,
  input  logic        in_funct7b5,
  input  logic        in_mem_read,
  input  logic        in_mem_write,
  input  logic        in_reg_write,
  input  logic        flush,
  input  logic [31:0] ex_result,
  input  logic [4:0]  mem_rd,
  input  logic        mem_reg_write,
  input  logic [31:0] mem_result,
  output logic        out_valid,
  output logic [31:0] A,
  output logic [31:0] B,
  output logic [3:0]  ALUcontrol,
  output logic [31:0] out_store_data,
  output logic [4:0]  out_rd,
  output logic        out_mem_read,
  output logic        out_mem_write,
  output logic        out_reg_write,
  output logic        out_branch,
  output logic [31:0] out_pc
);

  localparam logic [1:0] C_OP_R   = 2'b00;
  localparam logic [1:0] C_OP_I   = 2'b01;
  localparam logic [1:0] C_OP_LS  = 2'b10;
  localparam logic [1:0] C_OP_BR  = 2'b11;

  localparam logic [3:0] C_ALU_AND = 4'b0000;
  localparam logic [3:0] C_ALU_OR  = 4'b0001;
  localparam logic [3:0] C_ALU_ADD = 4'b0010;
  localparam logic [3:0] C_ALU_XOR = 4'b0011;
  localparam logic [3:0] C_ALU_SLL = 4'b0100;
  localparam logic [3:0] C_ALU_SRL = 4'b0101;
  localparam logic [3:0] C_ALU_SUB = 4'b0110;
  localparam logic [3:0] C_ALU_SRA = 4'b0111;
  localparam logic [3:0] C_ALU_BAD = 4'b1111;

  logic        w_uses_rs2;
  logic        w_ex_wr;
  logic        w_mem_wr;
  logic        w_hazard;
  logic        w_bubble;
  logic        w_shift;
  logic [31:0] w_rs1_val;
  logic [31:0] w_rs2_val;
  logic [31:0] w_b_sel;
  logic [31:0] w_b;
  logic [3:0]  w_alu;

  // rs2 is only a real source for R-type, branches and stores
  assign w_uses_rs2 = (in_op == C_OP_R) || (in_op == C_OP_BR) ||
                      ((in_op == C_OP_LS) && in_mem_write);
  assign w_ex_wr    = out_valid && out_reg_write && (out_rd != 5'd0);
  assign w_mem_wr   = mem_reg_write && (mem_rd != 5'd0);

`ifdef FORWARDING_EN
  always_comb begin
    w_rs1_val = in_rs1_data;
    w_rs2_val = in_rs2_data;
    if (w_ex_wr && (out_rd == in_rs1))
      w_rs1_val = ex_result;
    else if (w_mem_wr && (mem_rd == in_rs1))
      w_rs1_val = mem_result;
    if (w_ex_wr && (out_rd == in_rs2))
      w_rs2_val = ex_result;
    else if (w_mem_wr && (mem_rd == in_rs2))
      w_rs2_val = mem_result;
  end

  // a load in EX has no result yet, so a dependent instruction must wait
  assign w_hazard = in_valid && out_valid && out_mem_read && (out_rd != 5'd0) &&
                    ((out_rd == in_rs1) || (w_uses_rs2 && (out_rd == in_rs2)));
`else
  logic w_unused_fwd;

  assign w_unused_fwd = ^{ex_result, mem_result};
  assign w_rs1_val    = in_rs1_data;
  assign w_rs2_val    = in_rs2_data;

  // without bypass paths, wait until the producer has left MEM
  assign w_hazard = in_valid &&
                    ((w_ex_wr && ((out_rd == in_rs1) ||
                                  (w_uses_rs2 && (out_rd == in_rs2)))) ||
                     (w_mem_wr && ((mem_rd == in_rs1) ||
                                   (w_uses_rs2 && (mem_rd == in_rs2)))));
`endif

  assign in_ready = flush || !w_hazard;
  assign w_bubble = flush || !in_valid || w_hazard;

  always_comb begin
    w_alu = C_ALU_BAD;
    case (in_op)
      C_OP_R, C_OP_I: begin
        case (in_funct3)
          3'b000:  w_alu = (in_op == C_OP_R && in_funct7b5) ? C_ALU_SUB : C_ALU_ADD;
          3'b001:  w_alu = C_ALU_SLL;
          3'b100:  w_alu = C_ALU_XOR;
          3'b101:  w_alu = in_funct7b5 ? C_ALU_SRA : C_ALU_SRL;
          3'b110:  w_alu = C_ALU_OR;
          3'b111:  w_alu = C_ALU_AND;
          default: w_alu = C_ALU_BAD;
        endcase
      end
      C_OP_LS: w_alu = C_ALU_ADD;
      C_OP_BR: w_alu = C_ALU_SUB;
      default: w_alu = C_ALU_BAD;
    endcase
  end

  assign w_shift = ((in_op == C_OP_R) || (in_op == C_OP_I)) &&
                   ((in_funct3 == 3'b001) || (in_funct3 == 3'b101));
  assign w_b_sel = ((in_op == C_OP_R) || (in_op == C_OP_BR)) ? w_rs2_val : in_imm;
  assign w_b     = w_shift ? {27'd0, w_b_sel[4:0]} : w_b_sel;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid      <= 1'b0;
      A              <= 32'd0;
      B              <= 32'd0;
      ALUcontrol     <= C_ALU_BAD;
      out_store_data <= 32'd0;
      out_rd         <= 5'd0;
      out_mem_read   <= 1'b0;
      out_mem_write  <= 1'b0;
      out_reg_write  <= 1'b0;
      out_branch     <= 1'b0;
      out_pc         <= 32'd0;
    end else if (w_bubble) begin
      out_valid      <= 1'b0;
      A              <= 32'd0;
      B              <= 32'd0;
      ALUcontrol     <= C_ALU_BAD;
      out_store_data <= 32'd0;
      out_rd         <= 5'd0;
      out_mem_read   <= 1'b0;
      out_mem_write  <= 1'b0;
      out_reg_write  <= 1'b0;
      out_branch     <= 1'b0;
      out_pc         <= 32'd0;
    end else begin
      out_valid      <= 1'b1;
      A              <= w_rs1_val;
      B              <= w_b;
      ALUcontrol     <= w_alu;
      out_store_data <= w_rs2_val;
      out_rd         <= in_rd;
      out_mem_read   <= in_mem_read;
      out_mem_write  <= in_mem_write;
      out_reg_write  <= in_reg_write;
      out_branch     <= (in_op == C_OP_BR);
      out_pc         <= in_pc;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_id_ex_stage.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | tb_id_ex_stage: directed vectors and pipeline sequences for id_ex_stage|
// | Revision: 1.0                                                          |
// +------------------------------------------------------------------------+
module tb_id_ex_stage;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_rs1_data, in_rs2_data, in_imm, in_pc;
  logic [4:0]  in_rs1, in_rs2, in_rd;
  logic [1:0]  in_op;
  logic [2:0]  in_funct3;
  logic        in_funct7b5, in_mem_read, in_mem_write, in_reg_write;
  logic        flush;
  logic [31:0] ex_result;
  logic [4:0]  mem_rd;
  logic        mem_reg_write;
  logic [31:0] mem_result;
  logic        out_valid;
  logic [31:0] A, B;
  logic [3:0]  ALUcontrol;
  logic [31:0] out_store_data;
  logic [4:0]  out_rd;
  logic        out_mem_read, out_mem_write, out_reg_write, out_branch;
  logic [31:0] out_pc;

  int n_vec = 0;
  int n_err = 0;
  logic [31:0] pc_next = 32'h0000_1000;

  id_ex_stage dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_rs1_data(in_rs1_data), .in_rs2_data(in_rs2_data), .in_imm(in_imm), .in_pc(in_pc),
    .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd), .in_op(in_op),
    .in_funct3(in_funct3), .in_funct7b5(in_funct7b5), .in_mem_read(in_mem_read),
    .in_mem_write(in_mem_write), .in_reg_write(in_reg_write), .flush(flush),
    .ex_result(ex_result), .mem_rd(mem_rd), .mem_reg_write(mem_reg_write),
    .mem_result(mem_result), .out_valid(out_valid), .A(A), .B(B),
    .ALUcontrol(ALUcontrol), .out_store_data(out_store_data), .out_rd(out_rd),
    .out_mem_read(out_mem_read), .out_mem_write(out_mem_write),
    .out_reg_write(out_reg_write), .out_branch(out_branch), .out_pc(out_pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  op;
    logic [2:0]  f3;
    logic        f75;
    logic [31:0] rs1d;
    logic [31:0] rs2d;
    logic [31:0] imm;
    logic        mr;
    logic        mw;
    logic        rw;
    logic [3:0]  alu;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] st;
    logic        br;
  } vec_t;

  vec_t vecs [16];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic instr(input logic [1:0] op, input logic [2:0] f3, input logic f75,
                       input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                       input logic [31:0] d1, input logic [31:0] d2, input logic [31:0] imm,
                       input logic mr, input logic mw, input logic rw);
    in_valid     = 1'b1;
    in_op        = op;
    in_funct3    = f3;
    in_funct7b5  = f75;
    in_rs1       = rs1;
    in_rs2       = rs2;
    in_rd        = rd;
    in_rs1_data  = d1;
    in_rs2_data  = d2;
    in_imm       = imm;
    in_mem_read  = mr;
    in_mem_write = mw;
    in_reg_write = rw;
    in_pc        = pc_next;
    pc_next      = pc_next + 32'd4;
  endtask

  task automatic idle();
    in_valid = 1'b0;
  endtask

  task automatic clear_mem();
    mem_rd        = 5'd0;
    mem_reg_write = 1'b0;
    mem_result    = 32'd0;
    ex_result     = 32'd0;
  endtask

  initial begin
    vecs[0]  = '{2'b00, 3'b000, 1'b0, 32'd10, 32'd20, 32'h99, 1'b0, 1'b0, 1'b1, 4'b0010, 32'd10, 32'd20, 32'd20, 1'b0};
    vecs[1]  = '{2'b00, 3'b000, 1'b1, 32'd10, 32'd20, 32'h99, 1'b0, 1'b0, 1'b1, 4'b0110, 32'd10, 32'd20, 32'd20, 1'b0};
    vecs[2]  = '{2'b00, 3'b101, 1'b1, 32'h8000_0000, 32'h24, 32'h99, 1'b0, 1'b0, 1'b1, 4'b0111, 32'h8000_0000, 32'h4, 32'h24, 1'b0};
    vecs[3]  = '{2'b00, 3'b101, 1'b0, 32'h1234, 32'hFFFF_FFE3, 32'h99, 1'b0, 1'b0, 1'b1, 4'b0101, 32'h1234, 32'h3, 32'hFFFF_FFE3, 1'b0};
    vecs[4]  = '{2'b00, 3'b100, 1'b0, 32'hF0F0, 32'h0FF0, 32'h99, 1'b0, 1'b0, 1'b1, 4'b0011, 32'hF0F0, 32'h0FF0, 32'h0FF0, 1'b0};
    vecs[5]  = '{2'b00, 3'b110, 1'b0, 32'hF0F0, 32'h0FF0, 32'h99, 1'b0, 1'b0, 1'b1, 4'b0001, 32'hF0F0, 32'h0FF0, 32'h0FF0, 1'b0};
    vecs[6]  = '{2'b00, 3'b111, 1'b0, 32'hF0F0, 32'h0FF0, 32'h99, 1'b0, 1'b0, 1'b1, 4'b0000, 32'hF0F0, 32'h0FF0, 32'h0FF0, 1'b0};
    vecs[7]  = '{2'b00, 3'b010, 1'b0, 32'hF0F0, 32'h0FF0, 32'h99, 1'b0, 1'b0, 1'b1, 4'b1111, 32'hF0F0, 32'h0FF0, 32'h0FF0, 1'b0};
    vecs[8]  = '{2'b00, 3'b001, 1'b0, 32'd5, 32'h21, 32'h99, 1'b0, 1'b0, 1'b1, 4'b0100, 32'd5, 32'h1, 32'h21, 1'b0};
    vecs[9]  = '{2'b01, 3'b000, 1'b1, 32'd10, 32'd20, 32'hFFFF_FFF0, 1'b0, 1'b0, 1'b1, 4'b0010, 32'd10, 32'hFFFF_FFF0, 32'd20, 1'b0};
    vecs[10] = '{2'b01, 3'b001, 1'b0, 32'd10, 32'd20, 32'h45, 1'b0, 1'b0, 1'b1, 4'b0100, 32'd10, 32'h5, 32'd20, 1'b0};
    vecs[11] = '{2'b01, 3'b101, 1'b1, 32'd10, 32'd20, 32'h407, 1'b0, 1'b0, 1'b1, 4'b0111, 32'd10, 32'h7, 32'd20, 1'b0};
    vecs[12] = '{2'b01, 3'b011, 1'b0, 32'd10, 32'd20, 32'h77, 1'b0, 1'b0, 1'b1, 4'b1111, 32'd10, 32'h77, 32'd20, 1'b0};
    vecs[13] = '{2'b10, 3'b010, 1'b0, 32'h1000, 32'd20, 32'h8, 1'b1, 1'b0, 1'b1, 4'b0010, 32'h1000, 32'h8, 32'd20, 1'b0};
    vecs[14] = '{2'b10, 3'b010, 1'b0, 32'h1000, 32'hABCD, 32'hC, 1'b0, 1'b1, 1'b0, 4'b0010, 32'h1000, 32'hC, 32'hABCD, 1'b0};
    vecs[15] = '{2'b11, 3'b001, 1'b0, 32'd7, 32'h1234_5678, 32'h40, 1'b0, 1'b0, 1'b0, 4'b0110, 32'd7, 32'h1234_5678, 32'h1234_5678, 1'b1};

    reset = 1'b0;
    flush = 1'b0;
    in_valid = 1'b0; in_op = 2'b00; in_funct3 = 3'b000; in_funct7b5 = 1'b0;
    in_rs1 = 5'd0; in_rs2 = 5'd0; in_rd = 5'd0;
    in_rs1_data = 32'd0; in_rs2_data = 32'd0; in_imm = 32'd0; in_pc = 32'd0;
    in_mem_read = 1'b0; in_mem_write = 1'b0; in_reg_write = 1'b0;
    clear_mem();
    #1 reset = 1'b1;
    #1;
    chk("rst.out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst.ALUcontrol", {28'd0, ALUcontrol}, 32'hF);
    chk("rst.A", A, 32'd0);
    chk("rst.B", B, 32'd0);
    chk("rst.out_pc", out_pc, 32'd0);
    chk("rst.out_rd", {27'd0, out_rd}, 32'd0);
    chk("rst.out_reg_write", {31'd0, out_reg_write}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    tick();

    // table-driven decode vectors; an idle cycle between keeps EX empty
    for (int i = 0; i < 16; i++) begin
      logic [31:0] exp_pc;
      instr(vecs[i].op, vecs[i].f3, vecs[i].f75, 5'd1, 5'd2, 5'd3,
            vecs[i].rs1d, vecs[i].rs2d, vecs[i].imm, vecs[i].mr, vecs[i].mw, vecs[i].rw);
      exp_pc = in_pc;
      #1;
      chk($sformatf("v%0d.in_ready", i), {31'd0, in_ready}, 32'd1);
      tick();
      chk($sformatf("v%0d.out_valid", i), {31'd0, out_valid}, 32'd1);
      chk($sformatf("v%0d.ALUcontrol", i), {28'd0, ALUcontrol}, {28'd0, vecs[i].alu});
      chk($sformatf("v%0d.A", i), A, vecs[i].a);
      chk($sformatf("v%0d.B", i), B, vecs[i].b);
      chk($sformatf("v%0d.store", i), out_store_data, vecs[i].st);
      chk($sformatf("v%0d.rd", i), {27'd0, out_rd}, 32'd3);
      chk($sformatf("v%0d.ctl", i), {28'd0, out_mem_read, out_mem_write, out_reg_write, out_branch},
          {28'd0, vecs[i].mr, vecs[i].mw, vecs[i].rw, vecs[i].br});
      chk($sformatf("v%0d.pc", i), out_pc, exp_pc);
      idle();
      tick();
      chk($sformatf("v%0d.bubble", i), {31'd0, out_valid}, 32'd0);
    end

    // EX -> rs1 dependency (add x5 then use x5)
    instr(2'b00, 3'b000, 1'b0, 5'd1, 5'd2, 5'd5, 32'd3, 32'd4, 32'd0, 1'b0, 1'b0, 1'b1);
    tick();
    ex_result = 32'h1234;
    instr(2'b00, 3'b000, 1'b0, 5'd5, 5'd2, 5'd6, 32'hDEAD, 32'd7, 32'd0, 1'b0, 1'b0, 1'b1);
`ifdef FORWARDING_EN
    #1 chk("exfwd.in_ready", {31'd0, in_ready}, 32'd1);
    tick();
    chk("exfwd.A", A, 32'h1234);
    chk("exfwd.B", B, 32'd7);
    chk("exfwd.valid", {31'd0, out_valid}, 32'd1);
`else
    #1 chk("exstall1.in_ready", {31'd0, in_ready}, 32'd0);
    tick();
    chk("exstall1.valid", {31'd0, out_valid}, 32'd0);
    mem_rd = 5'd5; mem_reg_write = 1'b1; mem_result = 32'h1234;
    #1 chk("exstall2.in_ready", {31'd0, in_ready}, 32'd0);
    tick();
    chk("exstall2.valid", {31'd0, out_valid}, 32'd0);
    clear_mem();
    in_rs1_data = 32'h1234;
    #1 chk("exstall3.in_ready", {31'd0, in_ready}, 32'd1);
    tick();
    chk("exstall3.valid", {31'd0, out_valid}, 32'd1);
    chk("exstall3.A", A, 32'h1234);
`endif
    clear_mem();
    idle();
    tick();

`ifdef FORWARDING_EN
    // EX wins over MEM; then MEM alone forwards
    instr(2'b00, 3'b000, 1'b0, 5'd1, 5'd2, 5'd5, 32'd3, 32'd4, 32'd0, 1'b0, 1'b0, 1'b1);
    tick();
    ex_result = 32'h2222; mem_rd = 5'd5; mem_reg_write = 1'b1; mem_result = 32'h1111;
    instr(2'b00, 3'b000, 1'b0, 5'd5, 5'd5, 5'd6, 32'hDEAD, 32'hBEEF, 32'd0, 1'b0, 1'b0, 1'b0);
    tick();
    chk("prio.A", A, 32'h2222);
    chk("prio.B", B, 32'h2222);
    idle();
    tick();
    instr(2'b00, 3'b000, 1'b0, 5'd5, 5'd2, 5'd6, 32'hDEAD, 32'd9, 32'd0, 1'b0, 1'b0, 1'b0);
    tick();
    chk("memfwd.A", A, 32'h1111);
    clear_mem();
    idle();
    tick();
`endif

    // load x7 then R-type using x7 as rs2
    instr(2'b10, 3'b010, 1'b0, 5'd1, 5'd0, 5'd7, 32'h100, 32'd0, 32'd4, 1'b1, 1'b0, 1'b1);
    tick();
    ex_result = 32'h5555;
    instr(2'b00, 3'b000, 1'b0, 5'd1, 5'd7, 5'd8, 32'd1, 32'hBAD, 32'd0, 1'b0, 1'b0, 1'b1);
    #1 chk("lu1.in_ready", {31'd0, in_ready}, 32'd0);
    tick();
    chk("lu1.valid", {31'd0, out_valid}, 32'd0);
    chk("lu1.mem_read", {31'd0, out_mem_read}, 32'd0);
    mem_rd = 5'd7; mem_reg_write = 1'b1; mem_result = 32'hCAFE;
`ifdef FORWARDING_EN
    #1 chk("lu2.in_ready", {31'd0, in_ready}, 32'd1);
    tick();
`else
    #1 chk("lu2.in_ready", {31'd0, in_ready}, 32'd0);
    tick();
    chk("lu2.valid", {31'd0, out_valid}, 32'd0);
    clear_mem();
    in_rs2_data = 32'hCAFE;
    #1 chk("lu3.in_ready", {31'd0, in_ready}, 32'd1);
    tick();
`endif
    chk("lu.valid", {31'd0, out_valid}, 32'd1);
    chk("lu.B", B, 32'hCAFE);
    chk("lu.store", out_store_data, 32'hCAFE);
    clear_mem();
    idle();
    tick();

    // flush during a load-use stall
    instr(2'b10, 3'b010, 1'b0, 5'd1, 5'd0, 5'd7, 32'h100, 32'd0, 32'd4, 1'b1, 1'b0, 1'b1);
    tick();
    instr(2'b00, 3'b000, 1'b0, 5'd7, 5'd2, 5'd8, 32'd1, 32'd2, 32'd0, 1'b0, 1'b0, 1'b1);
    flush = 1'b1;
    #1 chk("flush.in_ready", {31'd0, in_ready}, 32'd1);
    tick();
    chk("flush.valid", {31'd0, out_valid}, 32'd0);
    chk("flush.reg_write", {31'd0, out_reg_write}, 32'd0);
    flush = 1'b0;
    idle();
    tick();

    // x0 is never forwarded nor stalled on
    instr(2'b00, 3'b000, 1'b0, 5'd1, 5'd2, 5'd0, 32'd1, 32'd2, 32'd0, 1'b0, 1'b0, 1'b1);
    tick();
    ex_result = 32'hFFFF; mem_rd = 5'd0; mem_reg_write = 1'b1; mem_result = 32'hEEEE;
    instr(2'b00, 3'b000, 1'b0, 5'd0, 5'd2, 5'd9, 32'd0, 32'd9, 32'd0, 1'b0, 1'b0, 1'b1);
    #1 chk("x0.in_ready", {31'd0, in_ready}, 32'd1);
    tick();
    chk("x0.A", A, 32'd0);
    chk("x0.valid", {31'd0, out_valid}, 32'd1);
    clear_mem();
    idle();
    tick();

    // asynchronous reset in the middle of a stall
    instr(2'b10, 3'b010, 1'b0, 5'd1, 5'd0, 5'd7, 32'h100, 32'd0, 32'd4, 1'b1, 1'b0, 1'b1);
    tick();
    instr(2'b00, 3'b000, 1'b0, 5'd3, 5'd7, 5'd8, 32'h33, 32'h77, 32'd0, 1'b0, 1'b0, 1'b1);
    #1 chk("arst.stall", {31'd0, in_ready}, 32'd0);
    #2 reset = 1'b1;
    #1;
    chk("arst.valid", {31'd0, out_valid}, 32'd0);
    chk("arst.ALUcontrol", {28'd0, ALUcontrol}, 32'hF);
    chk("arst.A", A, 32'd0);
    chk("arst.rd", {27'd0, out_rd}, 32'd0);
    chk("arst.mem_read", {31'd0, out_mem_read}, 32'd0);
    #1 reset = 1'b0;
    #1 chk("arst.in_ready", {31'd0, in_ready}, 32'd1);
    tick();
    chk("arst.first.valid", {31'd0, out_valid}, 32'd1);
    chk("arst.first.A", A, 32'h33);
    chk("arst.first.B", B, 32'h77);
    idle();
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
